pad_hit_encoder: RTL and testbench

Inverse of the pad selector in the trigger-info generator. The selector picks one pad bit by a 7-bit index; this block converts a captured 104-bit pad hit vector into a stream of 7-bit pad indices. Indices come out in ascending order over a valid/ready handshake, followed by a terminator word that carries the hit count and an overflow flag. It sits between the pad hit capture and the trigger-info packer, which consumes one index per accepted word.

---
 rtl/pad_hit_encoder.sv | 176 +++++++++++++++++
 tb/tb_pad_hit_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pad_hit_encoder.sv
// Turns a captured pad hit vector into a stream of ascending pad indices,
// closed by a terminator word that carries the hit count and an overflow flag.
module pad_hit_encoder #(
    parameter int                 PAD_NUM  = 104,
    parameter int                 IDX_W    = 7,
    parameter int                 MAX_HITS = 16,
    parameter int                 CNT_W    = 5,
    parameter logic [IDX_W-1:0]   TERM_IDX = {IDX_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PAD_NUM-1:0] pad_data,
    input  logic               pad_valid,
    output logic               busy,
    output logic [IDX_W-1:0]   hit_index,
    output logic               hit_valid,
    input  logic               hit_ready,
    output logic               hit_last,
    output logic [CNT_W-1:0]   hit_count,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        TERM = 2'd2
    } state_t;

    localparam logic [PAD_NUM-1:0] ONE_HOT0 = {{(PAD_NUM-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_HITS);

    state_t             state_q, state_d;
    logic [PAD_NUM-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0]   hit_index_q, hit_index_d;
    logic               hit_last_q, hit_last_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic               overflow_q, overflow_d;

    logic [PAD_NUM-1:0] rem_clr;
    logic [PAD_NUM-1:0] enc_in;
    logic [IDX_W-1:0]   enc_idx;
    logic [CNT_W-1:0]   cnt_inc;

    // Lowest set bit wins; scanning downward leaves the smallest index last.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [PAD_NUM-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = PAD_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // One shared encoder: capture looks at the fresh vector, EMIT at the
    // remaining vector with the word being accepted already removed.
    always_comb begin
        rem_clr = rem_q & ~(ONE_HOT0 << hit_index_q);
        cnt_inc = cnt_q + CNT_W'(1);
        enc_in  = (state_q == IDLE) ? pad_data : rem_clr;
        enc_idx = lowest_set(enc_in);
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        hit_valid_d = hit_valid_q;
        hit_index_d = hit_index_q;
        hit_last_d  = hit_last_q;
        hit_count_d = hit_count_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (pad_valid) begin
                    rem_d       = pad_data;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    hit_valid_d = 1'b1;
                    hit_count_d = '0;
                    overflow_d  = 1'b0;
                    if (|pad_data) begin
                        state_d     = EMIT;
                        hit_index_d = enc_idx;
                        hit_last_d  = 1'b0;
                    end else begin
                        state_d     = TERM;
                        hit_index_d = TERM_IDX;
                        hit_last_d  = 1'b1;
                    end
                end
            end

            EMIT: begin
                if (hit_ready) begin
                    rem_d = rem_clr;
                    cnt_d = cnt_inc;
                    if ((|rem_clr) && (cnt_inc < MAX_CNT)) begin
                        hit_index_d = enc_idx;
                    end else begin
                        state_d     = TERM;
                        hit_index_d = TERM_IDX;
                        hit_last_d  = 1'b1;
                        hit_count_d = cnt_inc;
                        overflow_d  = |rem_clr;
                    end
                end
            end

            TERM: begin
                // Leftover hits are dropped here so nothing leaks into the next event.
                if (hit_ready) begin
                    state_d     = IDLE;
                    rem_d       = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    hit_valid_d = 1'b0;
                    hit_index_d = '0;
                    hit_last_d  = 1'b0;
                    hit_count_d = '0;
                    overflow_d  = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                rem_d       = '0;
                cnt_d       = '0;
                busy_d      = 1'b0;
                hit_valid_d = 1'b0;
                hit_index_d = '0;
                hit_last_d  = 1'b0;
                hit_count_d = '0;
                overflow_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_index_q <= '0;
            hit_last_q  <= 1'b0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hit_valid_q <= hit_valid_d;
            hit_index_q <= hit_index_d;
            hit_last_q  <= hit_last_d;
            hit_count_q <= hit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = busy_q;
    assign hit_valid = hit_valid_q;
    assign hit_index = hit_index_q;
    assign hit_last  = hit_last_q;
    assign hit_count = hit_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pad_hit_encoder.sv
// Directed bench for pad_hit_encoder: empty, sparse, overflowing, backpressured,
// ignored-capture and mid-event-reset events.
module tb_pad_hit_encoder;

    logic         clk;
    logic         rst_n;
    logic [103:0] pad_data;
    logic         pad_valid;
    logic         busy;
    logic [6:0]   hit_index;
    logic         hit_valid;
    logic         hit_ready;
    logic         hit_last;
    logic [4:0]   hit_count;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    pad_hit_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pad_data  (pad_data),
        .pad_valid (pad_valid),
        .busy      (busy),
        .hit_index (hit_index),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_last  (hit_last),
        .hit_count (hit_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".valid"},     32'(hit_valid), 32'd0);
        chk({tag, ".index"},     32'(hit_index), 32'd0);
        chk({tag, ".last"},      32'(hit_last),  32'd0);
        chk({tag, ".count"},     32'(hit_count), 32'd0);
        chk({tag, ".overflow"},  32'(overflow),  32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic capture(input logic [103:0] v);
        pad_data  = v;
        pad_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pad_valid = 1'b0;
    endtask

    // Called at a negedge. Checks the presented word every cycle until accepted.
    task automatic expect_word(input string tag, input int idx, input bit last,
                               input int cnt, input bit ovf, input bit rnd);
        bit done;
        int waited;
        done   = 1'b0;
        waited = 0;
        while (!done && waited < 40) begin
            hit_ready = (rnd && waited < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            chk({tag, ".valid"}, 32'(hit_valid), 32'd1);
            chk({tag, ".busy"},  32'(busy),      32'd1);
            if (hit_valid) begin
                chk({tag, ".index"},    32'(hit_index), 32'(idx));
                chk({tag, ".last"},     32'(hit_last),  32'(last));
                chk({tag, ".count"},    32'(hit_count), 32'(cnt));
                chk({tag, ".overflow"}, 32'(overflow),  32'(ovf));
                if (hit_ready) done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        $display("word %s index=%0d last=%0d count=%0d overflow=%0d cycles=%0d",
                 tag, hit_index, hit_last, hit_count, overflow, waited);
        if (!done) chk({tag, ".timeout"}, 32'd1, 32'd0);
        hit_ready = 1'b1;
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".busy"},  32'(busy),      32'd0);
        chk({tag, ".valid"}, 32'(hit_valid), 32'd0);
    endtask

    initial begin
        logic [103:0] v;
        rst_n     = 1'b0;
        pad_data  = '0;
        pad_valid = 1'b0;
        hit_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("idle_after_reset");

        // Empty event: terminator only.
        capture('0);
        expect_word("empty.term", 127, 1, 0, 0, 0);
        expect_idle("empty.after");

        // Sparse event including the top pad.
        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[103] = 1'b1;
        capture(v);
        expect_word("sparse.w0", 0, 0, 0, 0, 0);
        expect_word("sparse.w1", 5, 0, 0, 0, 0);
        expect_word("sparse.w2", 103, 0, 0, 0, 0);
        expect_word("sparse.term", 127, 1, 3, 0, 0);
        expect_idle("sparse.after");

        // Twenty hits: only sixteen emitted, overflow flagged.
        v = '0;
        for (int i = 0; i < 20; i++) v[i] = 1'b1;
        capture(v);
        for (int i = 0; i < 16; i++) expect_word($sformatf("ovf.w%0d", i), i, 0, 0, 0, 0);
        expect_word("ovf.term", 127, 1, 16, 1, 0);
        expect_idle("ovf.after");

        // Random backpressure.
        v = '0; v[7] = 1'b1; v[64] = 1'b1;
        capture(v);
        expect_word("bp.w0", 7, 0, 0, 0, 1);
        expect_word("bp.w1", 64, 0, 0, 0, 1);
        expect_word("bp.term", 127, 1, 2, 0, 1);
        expect_idle("bp.after");

        // Captures during EMIT and on the terminator accept are ignored.
        v = '0; v[2] = 1'b1; v[9] = 1'b1;
        capture(v);
        expect_word("ign.w0", 2, 0, 0, 0, 0);
        v = '0; v[60] = 1'b1;
        pad_data  = v;
        pad_valid = 1'b1;
        expect_word("ign.w1", 9, 0, 0, 0, 0);
        expect_word("ign.term", 127, 1, 2, 0, 0);
        pad_valid = 1'b0;
        expect_idle("ign.after");
        v = '0; v[42] = 1'b1;
        capture(v);
        expect_word("late.w0", 42, 0, 0, 0, 0);
        expect_word("late.term", 127, 1, 1, 0, 0);
        expect_idle("late.after");

        // Asynchronous reset in the middle of an event.
        v = '0;
        for (int i = 10; i < 20; i++) v[i] = 1'b1;
        capture(v);
        expect_word("rst.w0", 10, 0, 0, 0, 0);
        expect_word("rst.w1", 11, 0, 0, 0, 0);
        expect_word("rst.w2", 12, 0, 0, 0, 0);
        chk("rst.w3_present", 32'(hit_index), 32'd13);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("rst.released");
        v = '0; v[1] = 1'b1;
        capture(v);
        expect_word("post.w0", 1, 0, 0, 0, 0);
        expect_word("post.term", 127, 1, 1, 0, 0);
        expect_idle("post.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
